// File: rtl/video_pkg.sv
// Shared raster timing defaults, pipeline stage and pixel types, and the
// RGB332 to RGB888 colour expansion used by the scan-out path.
package video_pkg;
    localparam int CW = 10;  // counter width; both 800 and 525 fit

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic in_win;
        logic irq;
    } stage_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bit replication so that full-scale 3/2-bit fields map to 8'hFF.
    function automatic rgb_t rgb332_to_888(input logic [7:0] p);
        rgb_t c;
        c.r = {p[7:5], p[7:5], p[7:6]};
        c.g = {p[4:2], p[4:2], p[4:3]};
        c.b = {4{p[1:0]}};
        return c;
    endfunction
endpackage

// File: rtl/video_timing.sv
// Free-running h/v raster counters plus the stage-0 sync, visible and
// start-of-vblank flags decoded directly from them.
module video_timing import video_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] h,
    output logic [CW-1:0] v,
    output logic          visible,
    output logic          hs_n,
    output logic          vs_n,
    output logic          blank_start
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_ON  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_OFF = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_ON  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_OFF = CW'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + CW'(1);
        end else begin
            h <= h + CW'(1);
        end
    end

    always_comb begin
        visible     = (h < H_VIS) && (v < V_VIS);
        hs_n        = !((h >= HS_ON) && (h < HS_OFF));
        vs_n        = !((v >= VS_ON) && (v < VS_OFF));
        blank_start = (h == '0) && (v == V_VIS);
    end
endmodule

// File: rtl/video_scanout.sv
// Raster scan-out: window address generation, two-stage output pipeline
// aligned to the registered framebuffer read, and RGB332 expansion.
module video_scanout import video_pkg::*; #(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int FB_WIDTH  = 128,
    parameter int FB_HEIGHT = 64,
    parameter int SCALE     = 4,
    parameter int X_OFFSET  = 64,
    parameter int Y_OFFSET  = 112
) (
    input  logic                                   clk,
    input  logic                                   reset,
    output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]  fb_addr,
    input  logic [7:0]                             fb_data,
    output logic                                   hsync,
    output logic                                   vsync,
    output logic                                   de,
    output logic [7:0]                             r,
    output logic [7:0]                             g,
    output logic [7:0]                             b,
    output logic                                   frame_irq
);
    localparam int AW     = $clog2(FB_WIDTH*FB_HEIGHT);
    localparam int LW     = (AW > CW) ? AW : CW;
    localparam int SHIFT  = $clog2(SCALE);
    localparam int STAGES = 2;

    localparam logic [CW-1:0] X_LO = CW'(X_OFFSET);
    localparam logic [CW-1:0] X_HI = CW'(X_OFFSET + FB_WIDTH*SCALE);
    localparam logic [CW-1:0] Y_LO = CW'(Y_OFFSET);
    localparam logic [CW-1:0] Y_HI = CW'(Y_OFFSET + FB_HEIGHT*SCALE);

    logic [CW-1:0]     h, v, dx, dy;
    logic              visible, hs_n, vs_n, blank_start, in_win;
    logic [LW-1:0]     lin;
    logic [STAGES:1]   vld_pipe;
    stage_t            s1;
    rgb_t              pix;

    video_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk),
        .reset(reset),
        .h(h),
        .v(v),
        .visible(visible),
        .hs_n(hs_n),
        .vs_n(vs_n),
        .blank_start(blank_start)
    );

    // Address is issued from stage-0 counters; the RAM answers in stage 1.
    always_comb begin
        in_win  = (h >= X_LO) && (h < X_HI) && (v >= Y_LO) && (v < Y_HI);
        dx      = h - X_LO;
        dy      = v - Y_LO;
        lin     = LW'(dy >> SHIFT) * LW'(FB_WIDTH) + LW'(dx >> SHIFT);
        fb_addr = in_win ? AW'(lin) : '0;
    end

    assign pix = rgb332_to_888(s1.in_win ? fb_data : 8'h00);
    assign de  = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            s1        <= '{hs_n: 1'b1, vs_n: 1'b1, in_win: 1'b0, irq: 1'b0};
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            frame_irq <= 1'b0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], visible};
            s1        <= '{hs_n: hs_n, vs_n: vs_n, in_win: in_win, irq: blank_start};
            hsync     <= s1.hs_n;
            vsync     <= s1.vs_n;
            frame_irq <= s1.irq;
            {r, g, b} <= vld_pipe[1] ? pix : '0;
        end
    end
endmodule

// File: tb/tb_video_scanout.sv
// Bench for video_scanout: one full-timing instance and two reduced-timing
// instances checked every cycle against a cycle-index raster model.
module tb_video_scanout;
    typedef struct packed {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, fw, fh, sc, xo, yo;
    } cfg_t;

    localparam cfg_t C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 128, 64, 4, 64, 112};
    localparam cfg_t C1 = '{64, 4, 8, 4, 40, 2, 2, 3, 16, 8, 2, 16, 12};
    localparam cfg_t C2 = '{64, 4, 8, 4, 40, 2, 2, 3, 8, 4, 4, 16, 12};

    typedef struct {
        logic de, hs, vs, irq, inwin;
        int   addr;
    } ref_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [12:0] fb_addr0;
    logic [6:0]  fb_addr1;
    logic [4:0]  fb_addr2;
    logic [7:0]  fb_data0, fb_data1, fb_data2;
    logic        hsync0, vsync0, de0, irq0;
    logic        hsync1, vsync1, de1, irq1;
    logic        hsync2, vsync2, de2, irq2;
    logic [7:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;

    logic [7:0] mem0 [8192];
    logic [7:0] mem1 [128];
    logic [7:0] mem2 [32];

    always @(posedge clk) begin
        fb_data0 <= mem0[fb_addr0];
        fb_data1 <= mem1[fb_addr1];
        fb_data2 <= mem2[fb_addr2];
    end

    video_scanout u0 (
        .clk(clk), .reset(reset), .fb_addr(fb_addr0), .fb_data(fb_data0),
        .hsync(hsync0), .vsync(vsync0), .de(de0), .r(r0), .g(g0), .b(b0),
        .frame_irq(irq0)
    );

    video_scanout #(
        .H_ACTIVE(C1.ha), .H_FP(C1.hfp), .H_SYNC(C1.hs), .H_BP(C1.hbp),
        .V_ACTIVE(C1.va), .V_FP(C1.vfp), .V_SYNC(C1.vs), .V_BP(C1.vbp),
        .FB_WIDTH(C1.fw), .FB_HEIGHT(C1.fh), .SCALE(C1.sc),
        .X_OFFSET(C1.xo), .Y_OFFSET(C1.yo)
    ) u1 (
        .clk(clk), .reset(reset), .fb_addr(fb_addr1), .fb_data(fb_data1),
        .hsync(hsync1), .vsync(vsync1), .de(de1), .r(r1), .g(g1), .b(b1),
        .frame_irq(irq1)
    );

    video_scanout #(
        .H_ACTIVE(C2.ha), .H_FP(C2.hfp), .H_SYNC(C2.hs), .H_BP(C2.hbp),
        .V_ACTIVE(C2.va), .V_FP(C2.vfp), .V_SYNC(C2.vs), .V_BP(C2.vbp),
        .FB_WIDTH(C2.fw), .FB_HEIGHT(C2.fh), .SCALE(C2.sc),
        .X_OFFSET(C2.xo), .Y_OFFSET(C2.yo)
    ) u2 (
        .clk(clk), .reset(reset), .fb_addr(fb_addr2), .fb_data(fb_data2),
        .hsync(hsync2), .vsync(vsync2), .de(de2), .r(r2), .g(g2), .b(b2),
        .frame_irq(irq2)
    );

    int checks = 0;
    int errors = 0;
    int k = 0;          // cycles since the last reset edge; raster index
    int irq_k[$];

    // Raster state at cycle index k, from the timing rules alone.
    function automatic ref_t ref_at(int kk, cfg_t c);
        ref_t rf;
        int ht, ft, n, h, v;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        ft = ht * (c.va + c.vfp + c.vs + c.vbp);
        n  = ((kk % ft) + ft) % ft;
        h  = n % ht;
        v  = n / ht;
        rf.de    = (h < c.ha) && (v < c.va);
        rf.hs    = !((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs));
        rf.vs    = !((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs));
        rf.irq   = (h == 0) && (v == c.va);
        rf.inwin = (h >= c.xo) && (h < c.xo + c.fw * c.sc) &&
                   (v >= c.yo) && (v < c.yo + c.fh * c.sc);
        rf.addr  = rf.inwin ? ((v - c.yo) / c.sc) * c.fw + (h - c.xo) / c.sc : 0;
        return rf;
    endfunction

    function automatic logic [23:0] rgb888(logic [7:0] p);
        int r3, g3, b2;
        r3 = int'(p) / 32;
        g3 = (int'(p) / 4) % 8;
        b2 = int'(p) % 4;
        return {8'(r3 * 73 / 2), 8'(g3 * 73 / 2), 8'(b2 * 85)};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic chk_dut(string tag, ref_t rp, int exp_addr, logic [7:0] byte_at,
                           logic [31:0] addr, logic hs, logic vs, logic d,
                           logic irq, logic [23:0] rgb);
        chk({tag, ".addr"}, addr, 32'(exp_addr));
        chk({tag, ".hsync"}, 32'(hs), 32'(rp.hs));
        chk({tag, ".vsync"}, 32'(vs), 32'(rp.vs));
        chk({tag, ".de"}, 32'(d), 32'(rp.de));
        chk({tag, ".irq"}, 32'(irq), 32'(rp.irq));
        chk({tag, ".rgb"}, 32'(rgb),
            rp.de ? 32'(rgb888(rp.inwin ? byte_at : 8'h00)) : 32'h0);
    endtask

    // One clock: track the raster index, then check all three instances.
    task automatic step();
        ref_t rp;
        @(posedge clk);
        k = reset ? 0 : k + 1;
        @(negedge clk);
        rp = ref_at(k - 2, C0);
        chk_dut("u0", rp, ref_at(k, C0).addr, mem0[rp.addr], 32'(fb_addr0),
                hsync0, vsync0, de0, irq0, {r0, g0, b0});
        rp = ref_at(k - 2, C1);
        chk_dut("u1", rp, ref_at(k, C1).addr, mem1[rp.addr], 32'(fb_addr1),
                hsync1, vsync1, de1, irq1, {r1, g1, b1});
        rp = ref_at(k - 2, C2);
        chk_dut("u2", rp, ref_at(k, C2).addr, mem2[rp.addr], 32'(fb_addr2),
                hsync2, vsync2, de2, irq2, {r2, g2, b2});
    endtask

    initial begin
        int first_hs, hs_cnt, k_rst, rlen;

        for (int i = 0; i < 8192; i++) mem0[i] = 8'(i);
        for (int i = 0; i < 128; i++)  mem1[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 32; i++)   mem2[i] = 8'($urandom_range(0, 255));

        // Power-on reset, then two small frames and the first lines of u0.
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        first_hs = -1;
        hs_cnt   = 0;
        repeat (7720) begin
            step();
            if (hsync0 === 1'b0) begin
                if (first_hs < 0) first_hs = k;
                if (k < 802) hs_cnt++;
            end
            if (irq1 === 1'b1) irq_k.push_back(k);
        end
        chk("u0.hsync_first", 32'(first_hs), 32'd658);
        chk("u0.hsync_width", 32'(hs_cnt), 32'd96);
        chk("u1.irq_count", 32'(irq_k.size()), 32'd2);
        chk("u1.irq_first", 32'(irq_k[0]), 32'd3202);
        chk("u1.frame_len", 32'(irq_k[1] - irq_k[0]), 32'd3760);

        // All-white framebuffer; reset lands while the irq flag is in flight.
        reset = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 128; i++) mem1[i] = 8'hFF;
        for (int i = 0; i < 32; i++)  mem2[i] = 8'hFF;
        step();
        reset = 1'b0;
        while (k != 3201) step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        irq_k.delete();
        repeat (3770) begin
            step();
            if (irq1 === 1'b1) irq_k.push_back(k);
        end
        chk("u1.irq_after_reset", 32'(irq_k.size()), 32'd1);
        chk("u1.irq_restart", 32'(irq_k[0]), 32'd3202);

        // Random contents and a random mid-frame reset of random length.
        reset = 1'b1;
        step();
        for (int i = 0; i < 8192; i++) mem0[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 128; i++)  mem1[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 32; i++)   mem2[i] = 8'($urandom_range(0, 255));
        step();
        reset = 1'b0;
        k_rst = $urandom_range(100, 3700);
        while (k < k_rst) step();
        reset = 1'b1;
        rlen = $urandom_range(1, 4);
        repeat (rlen) step();
        reset = 1'b0;
        repeat (3770) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_scanout.md
# video_scanout

Raster scan-out stage downstream of the framebuffer: generates 640x480@60 Hz sync timing, reads pixel bytes from the framebuffer's byte-wide read port one cycle ahead, upscales a 128x64 RGB332 image by 4 into a centred 512x256 window and drives 24-bit RGB, syncs and data-enable to the HDMI/DVI encoder. Also emits a start-of-vblank pulse for the CPU interrupt controller.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch/sync widths (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync widths (lines)
- FB_WIDTH / FB_HEIGHT, 128 / 64, framebuffer image size (pixels)
- SCALE, 4, pixel replication factor; power of two only
- X_OFFSET / Y_OFFSET, 64 / 112, top-left of image window in raster coordinates
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- fb_addr  out  $clog2(FB_WIDTH*FB_HEIGHT) (13)  framebuffer read byte address
- fb_data  in  8  pixel byte, valid one cycle after fb_addr (registered RAM output)
- hsync, vsync  out  1  active-low sync
- de  out  1  data enable, high in visible area
- r, g, b  out  8 each  pixel colour
- frame_irq  out  1  one-cycle pulse at start of vertical blank

## Operation
- Counters: h 0..H_TOTAL-1 (H_TOTAL=800), v 0..V_TOTAL-1 (V_TOTAL=525); h wraps to 0 and v increments on h=H_TOTAL-1; v wraps to 0 after V_TOTAL-1 at end of line.
- Stage 0 (counter cycle): visible = h<H_ACTIVE && v<V_ACTIVE; hs_n low iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs_n likewise on v; in_win = X_OFFSET <= h < X_OFFSET+FB_WIDTH*SCALE and same for v with Y_OFFSET/FB_HEIGHT.
- fb_addr (combinational from stage-0 counters): ((v-Y_OFFSET)>>log2(SCALE))*FB_WIDTH + ((h-X_OFFSET)>>log2(SCALE)) when in_win, else 0. Address arithmetic at 10-bit widths, truncated to fb_addr width.
- Stage 1: register visible, hs_n, vs_n, in_win, irq flag (h=0 && v=V_ACTIVE); fb_data valid this cycle.
- Stage 2 (output regs): de=visible; hsync/vsync from stage 1; pixel p = in_win ? fb_data : 8'h00; expand RGB332: r={p[7:5],p[7:5],p[7:6]}, g={p[4:2],p[4:2],p[4:3]}, b={p[1:0],p[1:0],p[1:0],p[1:0]}; when !visible r=g=b=0.
- frame_irq = stage-1 irq flag, exactly one cycle per frame.
- Block never writes the framebuffer; no backpressure, free-running.

## Timing
- Latency: outputs reflect counter state of 2 cycles earlier; all sync/de/rgb/irq share this latency exactly (no skew).
- Reset: counters (0,0); pipeline regs cleared; outputs hsync=1, vsync=1, de=0, r=g=b=0, frame_irq=0; fb_addr follows counters, i.e. 0 during reset.
- First cycle with reset low: counters at (0,0); de rises on the second rising edge after that cycle.
- Reset mid-frame: counters return to (0,0) on the edge reset is sampled; outputs forced to reset values the same edge; no partial irq pulse.
- Window boundary: h=X_OFFSET-1 black, h=X_OFFSET reads byte 0 of the row; pixels X_OFFSET..X_OFFSET+3 all address column 0.
- Line/frame wrap: (799,524) -> (0,0) in one cycle.

## Structure
- Package video_pkg: default 640x480 timing constants, H_TOTAL/V_TOTAL, RGB332-to-RGB888 expansion function.
- Sub-module video_timing: h/v counters, sync, visible and blank-start flags at stage 0; video_scanout adds window/address, pipeline and colour expansion.

## Test plan
- Reset released, run one full frame -> hsync low for exactly 96 cycles per line starting 656 cycles after de rise; vsync low for exactly 2 lines; 420000 cycles per frame.
- Model framebuffer with byte n = n[7:0] -> at raster (64,112) rgb from byte 0 (000000), at (68,112) byte 1 (r=g=0, b=8'h55), at (64,116) byte 128 (byte 8'h80: r=8'h92, g=0, b=0).
- fb_data=8'hFF everywhere -> r=g=b=8'hFF only for h in 64..575, v in 112..367; black elsewhere in visible area; 0 whenever de=0.
- Check frame_irq -> exactly one pulse per frame, 2 cycles after counters reach (0,480), coincident with first de-low line output.
- Assert reset at (300,200) for 3 cycles -> outputs at reset values next edge; after release timing restarts at (0,0) with no glitch pulse on frame_irq.
- Override SCALE=2, X_OFFSET=192, Y_OFFSET=176 -> window 256x128 centred, fb_addr increments every 2 pixels and each row every 2 lines.
